triangle_assembler: RTL
=======================

TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 Parameter VERTEX_WIDTH, 12, signed screen-space coordinate width.
REQ-002 Parameter IDX_ADDR_WIDTH, 10, index-buffer address width.
REQ-003 Parameter VTX_ADDR_WIDTH, 8, vertex-buffer address width; an index value is a vertex address.
REQ-004 Parameter CULL_BACKFACE, 1, when 1 the block drops clockwise (negative-area) triangles.
REQ-005 Port clk input 1, single clock; all logic is on its rising edge.
REQ-006 Port rst input 1, asynchronous active-high reset.
REQ-007 Port start input 1, one-cycle pulse that begins a batch; ignored unless in IDLE.
REQ-008 Port num_triangles input IDX_ADDR_WIDTH, triangle count, sampled on start.
REQ-009 Port idx_addr output IDX_ADDR_WIDTH, index-RAM read address.
REQ-010 Port idx_data input VTX_ADDR_WIDTH, index-RAM data, valid one cycle after idx_addr.
REQ-011 Port vtx_addr output VTX_ADDR_WIDTH, vertex-RAM read address.
REQ-012 Port vtx_data input 2*VERTEX_WIDTH, {x,y} signed, valid one cycle after vtx_addr.
REQ-013 Ports x0,y0,x1,y1,x2,y2 output VERTEX_WIDTH each, signed triangle to the rasterizer.
REQ-014 Port tri_valid output 1, triangle outputs hold a triangle.
REQ-015 Port tri_ready input 1, rasterizer accepts the triangle.
REQ-016 Port busy output 1, high whenever state is not IDLE.
REQ-017 Port done output 1, one-cycle pulse when the batch completes.

Function
REQ-018 States: IDLE, FETCH_IDX, FETCH_VTX, CULL, EMIT, DONE.
REQ-019 IDLE -> FETCH_IDX on start with num_triangles > 0; IDLE -> DONE on start with num_triangles = 0.
REQ-020 Triangle t uses index words 3t, 3t+1, 3t+2; idx_addr is a running counter starting at 0 per batch.
REQ-021 FETCH_IDX issues three consecutive addresses and captures three indices, taking 4 cycles, then moves to FETCH_VTX.
REQ-022 FETCH_VTX issues the three captured indices in order and captures vertices v0, v1, v2, taking 4 cycles, then moves to CULL.
REQ-023 CULL computes area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) at 2*VERTEX_WIDTH+2 bits signed, with no overflow possible; the result is registered, taking 1 cycle.
REQ-024 Triangle is dropped when area = 0, or when CULL_BACKFACE = 1 and area < 0; otherwise CULL -> EMIT.
REQ-025 EMIT drives tri_valid = 1 with x0..y2 stable until the cycle where tri_valid && tri_ready; it then advances.
REQ-026 Advance: if the triangle counter reaches num_triangles -> DONE; otherwise -> FETCH_IDX. A dropped triangle advances the same way directly from CULL.
REQ-027 tri_valid is never asserted outside EMIT; tri_ready outside EMIT has no effect.
REQ-028 DONE pulses done for 1 cycle, then returns to IDLE.
REQ-029 Minimum latency from start to first tri_valid is 10 cycles.
REQ-030 Index values reaching vertex RAM are truncated to VTX_ADDR_WIDTH with no range check.
REQ-031 start while busy is ignored, and num_triangles is not resampled.

Reset
REQ-032 rst forces IDLE at any time, including mid-batch or mid-handshake; the in-flight triangle is discarded.
REQ-033 Reset values: tri_valid=0, done=0, busy=0, idx_addr=0, vtx_addr=0, x0..y2=0, and the triangle counter=0.

Structure
REQ-034 The state enum and the area-width constant belong in the shared render-pipeline package.
REQ-035 The signed-area computation is one sub-module, edge_area, that is combinational and is registered by the parent.

Verification
REQ-036 start, n=1, indices {0,1,2}, v0=(0,0), v1=(10,0), v2=(0,10), tri_ready=1 -> tri_valid at cycle 10 with those coordinates, done one cycle after the handshake.
REQ-037 Same batch with v1 and v2 swapped, CULL_BACKFACE=1 -> no tri_valid, done pulses; with CULL_BACKFACE=0 -> the triangle is emitted.
REQ-038 Collinear vertices (0,0), (5,5), (10,10) -> dropped regardless of CULL_BACKFACE.
REQ-039 n=3, tri_ready held low for 20 cycles on triangle 2 -> outputs stable throughout; exactly 3 handshakes occur, in order.
REQ-040 rst asserted during EMIT of triangle 1 of 3 -> next cycle IDLE with all outputs at reset values; a new start then re-fetches from idx_addr 0.
REQ-041 start with n=0 -> done after 1 cycle with no memory reads; start pulsed while busy -> batch unaffected.

Source files
------------

// File: rtl/triangle_assembler_pkg.sv
// triangle_assembler_pkg: shared render-pipeline types and area sizing.
package triangle_assembler_pkg;
  typedef enum logic [2:0] {IDLE, FETCH_IDX, FETCH_VTX, CULL, EMIT, DONE} state_e;
  function automatic int area_width(input int vertex_width);
    return 2 * vertex_width + 2;
  endfunction
  localparam int AREA_WIDTH = area_width(12);
endpackage

// File: rtl/triangle_assembler_edge_area.sv
// edge_area: twice the signed triangle area, positive for counter-clockwise winding.
module edge_area #(
  parameter int VERTEX_WIDTH = 12,
  parameter int AREA_WIDTH = 2 * VERTEX_WIDTH + 2
) (
  input  logic signed [VERTEX_WIDTH-1:0] x0,
  input  logic signed [VERTEX_WIDTH-1:0] y0,
  input  logic signed [VERTEX_WIDTH-1:0] x1,
  input  logic signed [VERTEX_WIDTH-1:0] y1,
  input  logic signed [VERTEX_WIDTH-1:0] x2,
  input  logic signed [VERTEX_WIDTH-1:0] y2,
  output logic signed [AREA_WIDTH-1:0]   area
);
  logic signed [AREA_WIDTH-1:0] dx1, dy1, dx2, dy2;
  always_comb begin
    dx1 = AREA_WIDTH'(x1) - AREA_WIDTH'(x0);
    dy1 = AREA_WIDTH'(y1) - AREA_WIDTH'(y0);
    dx2 = AREA_WIDTH'(x2) - AREA_WIDTH'(x0);
    dy2 = AREA_WIDTH'(y2) - AREA_WIDTH'(y0);
    area = dx1 * dy2 - dx2 * dy1;
  end
endmodule

// File: rtl/triangle_assembler.sv
// triangle_assembler: fetches indexed triangles from index/vertex RAM, culls
// degenerate and back-facing ones and hands the rest to the rasterizer.
module triangle_assembler
  import triangle_assembler_pkg::*;
#(
  parameter int VERTEX_WIDTH   = 12,
  parameter int IDX_ADDR_WIDTH = 10,
  parameter int VTX_ADDR_WIDTH = 8,
  parameter bit CULL_BACKFACE  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [IDX_ADDR_WIDTH-1:0]      num_triangles,
  output logic [IDX_ADDR_WIDTH-1:0]      idx_addr,
  input  logic [VTX_ADDR_WIDTH-1:0]      idx_data,
  output logic [VTX_ADDR_WIDTH-1:0]      vtx_addr,
  input  logic [2*VERTEX_WIDTH-1:0]      vtx_data,
  output logic signed [VERTEX_WIDTH-1:0] x0,
  output logic signed [VERTEX_WIDTH-1:0] y0,
  output logic signed [VERTEX_WIDTH-1:0] x1,
  output logic signed [VERTEX_WIDTH-1:0] y1,
  output logic signed [VERTEX_WIDTH-1:0] x2,
  output logic signed [VERTEX_WIDTH-1:0] y2,
  output logic                           tri_valid,
  input  logic                           tri_ready,
  output logic                           busy,
  output logic                           done
);
  localparam int AW = area_width(VERTEX_WIDTH);
  state_e state_q;
  logic [1:0] sub_q;
  logic [IDX_ADDR_WIDTH-1:0] n_q, cnt_q, cnt_d;
  logic [1:0][VTX_ADDR_WIDTH-1:0] idx_q;
  logic signed [VERTEX_WIDTH-1:0] vx, vy;
  logic signed [AW-1:0] area_d, area_q;
  logic keep, adv, last;
  assign {vx, vy} = vtx_data;
  assign cnt_d = cnt_q + IDX_ADDR_WIDTH'(1);
  assign last = cnt_d == n_q;
  assign keep = area_q != '0 && (!CULL_BACKFACE || !area_q[AW-1]);
  assign adv = (state_q == CULL && !keep) || (state_q == EMIT && tri_ready);
  // v2 is taken straight off the vertex bus so the area is registered as the last vertex lands
  edge_area #(.VERTEX_WIDTH(VERTEX_WIDTH), .AREA_WIDTH(AW)) u_area (
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(vx), .y2(vy), .area(area_d)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sub_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      area_q <= '0;
      idx_addr <= '0;
      vtx_addr <= '0;
      {x0, y0, x1, y1, x2, y2} <= '0;
      tri_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          n_q <= num_triangles;
          cnt_q <= '0;
          idx_addr <= '0;
          sub_q <= '0;
          busy <= 1'b1;
          done <= num_triangles == '0;
          state_q <= num_triangles == '0 ? DONE : FETCH_IDX;
        end
        FETCH_IDX: begin
          sub_q <= sub_q + 2'd1;
          if (sub_q != 2'd3) idx_addr <= idx_addr + IDX_ADDR_WIDTH'(1);
          if (sub_q != 2'd0) idx_q <= {idx_data, idx_q[1]};
          if (sub_q == 2'd3) begin
            vtx_addr <= idx_q[0];
            state_q <= FETCH_VTX;
          end
        end
        FETCH_VTX: begin
          sub_q <= sub_q + 2'd1;
          if (sub_q == 2'd0) idx_q[0] <= idx_q[1];
          if (sub_q < 2'd2) vtx_addr <= idx_q[0];
          if (sub_q == 2'd1) {x0, y0} <= vtx_data;
          if (sub_q == 2'd2) {x1, y1} <= vtx_data;
          if (sub_q == 2'd3) begin
            {x2, y2} <= vtx_data;
            area_q <= area_d;
            state_q <= CULL;
          end
        end
        CULL: if (keep) begin
          tri_valid <= 1'b1;
          state_q <= EMIT;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: ;
      endcase
      if (adv) begin
        cnt_q <= cnt_d;
        tri_valid <= 1'b0;
        done <= last;
        state_q <= last ? DONE : FETCH_IDX;
      end
    end
  end
endmodule
